// File: rtl/igrtu12.sv
// igrtu12 -- TU12 multiframe transmitter for one read-bus slot.
//
// Builds the 144-byte TU12 multiframe (four 36-byte frames, each led by a
// pointer byte V1..V4) from E1 bytes buffered in a 16-entry FIFO. Inserts a
// fixed pointer, V5 with running BIP-2, J2/N2/K4 as zero bytes and one fixed
// stuff byte after each POH byte. Underrun inserts 8'hFF and flags undflw.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   txsof             multiframe start: the next slot read is byte 0 (V1)
//   din_vld/datain    E1 byte offer; din_rdy accepts it (FIFO not full)
//   rden/addrrd       slot read request, serviced when addrrd == ADDR
//   dout/dout_vld     transmitted byte, one cycle after a serviced read
//   rei_in/rdi_in     far-end indications placed in V5
//   fifo_lvl          FIFO occupancy 0..16
//   undflw            pulses with dout_vld when a fill byte replaces data
module igrtu12 #(
    parameter logic [4:0] ADDR   = 5'b0,
    parameter int         WIDTH  = 8,
    parameter logic [9:0] OFFSET = 10'd0,
    parameter logic [2:0] SLABEL = 3'b010
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             txsof,
    input  logic             din_vld,
    input  logic [WIDTH-1:0] datain,
    output logic             din_rdy,
    input  logic             rden,
    input  logic [4:0]       addrrd,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    input  logic             rei_in,
    input  logic             rdi_in,
    output logic [4:0]       fifo_lvl,
    output logic             undflw
);
    // Positions are within a 36-byte frame where 0 is the pointer byte.
    localparam logic [5:0] POH_POS  = 6'((OFFSET % 10'd35) + 10'd1);
    localparam logic [5:0] R_POS    = 6'((((OFFSET % 10'd35) + 10'd1) % 10'd35) + 10'd1);
    // V5 sits in the frame after the one the pointer value falls in; the
    // 2-bit truncation wraps frame 4 back to frame 0.
    localparam logic [1:0] V5_FRAME = 2'((OFFSET / 10'd35) + 10'd1);

    function automatic logic [1:0] bip_of(input logic [7:0] b);
        return {b[7] ^ b[5] ^ b[3] ^ b[1], b[6] ^ b[4] ^ b[2] ^ b[0]};
    endfunction

    logic [7:0]       row_q, row_d, row_eff;
    logic [1:0]       frame;
    logic [5:0]       pos;
    logic [1:0]       bip_q, bip_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_vld_q, dout_vld_d;
    logic             undflw_q, undflw_d;
    logic [WIDTH-1:0] mem_q [16];
    logic [3:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [4:0]       lvl_q, lvl_d;

    logic             svc, wr, pop;
    logic             is_ptr, is_poh, is_v5, is_r, is_data;
    logic [WIDTH-1:0] v5_byte, tx_byte;

    always_comb begin
        row_eff = txsof ? 8'd0 : row_q;
        if (row_eff >= 8'd108) begin
            frame = 2'd3;
            pos   = 6'(row_eff - 8'd108);
        end else if (row_eff >= 8'd72) begin
            frame = 2'd2;
            pos   = 6'(row_eff - 8'd72);
        end else if (row_eff >= 8'd36) begin
            frame = 2'd1;
            pos   = 6'(row_eff - 8'd36);
        end else begin
            frame = 2'd0;
            pos   = row_eff[5:0];
        end
    end

    always_comb begin
        svc     = rden && (addrrd == ADDR);
        din_rdy = (lvl_q != 5'd16);
        wr      = din_vld && din_rdy;

        is_ptr  = (pos == 6'd0);
        is_poh  = !is_ptr && (pos == POH_POS);
        is_v5   = is_poh && (frame == V5_FRAME);
        is_r    = !is_ptr && !is_poh && (pos == R_POS);
        is_data = !is_ptr && !is_poh && !is_r;

        v5_byte = WIDTH'({bip_q, rei_in, 1'b0, SLABEL, rdi_in});

        tx_byte = '1;
        if (is_ptr) begin
            case (frame)
                2'd0:    tx_byte = WIDTH'({4'b0110, 2'b10, OFFSET[9:8]});
                2'd1:    tx_byte = WIDTH'(OFFSET[7:0]);
                default: tx_byte = '0;
            endcase
        end else if (is_v5) begin
            tx_byte = v5_byte;
        end else if (is_poh) begin
            tx_byte = '0;
        end else if (is_r) begin
            tx_byte = '1;
        end else if (lvl_q != 5'd0) begin
            tx_byte = mem_q[rd_ptr_q];
        end

        // Pop decision uses the occupancy before this cycle's write, so a
        // byte written into an empty FIFO is never forwarded the same cycle.
        pop = svc && is_data && (lvl_q != 5'd0);

        row_d = row_eff;
        if (svc) begin
            row_d = (row_eff == 8'd143) ? 8'd0 : row_eff + 8'd1;
        end

        // V1..V4 never contribute; V5 restarts the accumulation with itself.
        bip_d = bip_q;
        if (svc && !is_ptr) begin
            bip_d = is_v5 ? bip_of(v5_byte[7:0]) : (bip_q ^ bip_of(tx_byte[7:0]));
        end

        dout_d     = svc ? tx_byte : dout_q;
        dout_vld_d = svc;
        undflw_d   = svc && is_data && (lvl_q == 5'd0);

        wr_ptr_d = wr  ? wr_ptr_q + 4'd1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 4'd1 : rd_ptr_q;
        lvl_d    = lvl_q + {4'd0, wr} - {4'd0, pop};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q      <= 8'd0;
            bip_q      <= 2'd0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            undflw_q   <= 1'b0;
            wr_ptr_q   <= 4'd0;
            rd_ptr_q   <= 4'd0;
            lvl_q      <= 5'd0;
        end else begin
            row_q      <= row_d;
            bip_q      <= bip_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
            undflw_q   <= undflw_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            lvl_q      <= lvl_d;
        end
    end

    // Storage needs no reset; the cleared pointers make it empty.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem_q[wr_ptr_q] <= datain;
        end
    end

    assign dout     = dout_q;
    assign dout_vld = dout_vld_q;
    assign undflw   = undflw_q;
    assign fifo_lvl = lvl_q;

endmodule

// File: tb/tb_igrtu12.sv
module tb_igrtu12;
    localparam logic [4:0] SLOT = 5'd3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       txsof = 1'b0;
    logic       rden = 1'b0;
    logic [4:0] addrrd = 5'd0;
    logic       rei = 1'b0, rdi = 1'b0;
    logic       din_vld0 = 1'b0, din_vld1 = 1'b0;
    logic [7:0] datain0 = 8'd0, datain1 = 8'd0;

    logic [7:0] dout0, dout1;
    logic       vld0, vld1, rdy0, rdy1, uf0, uf1;
    logic [4:0] lvl0, lvl1;

    always #5 clk = ~clk;

    igrtu12 #(.ADDR(SLOT), .WIDTH(8), .OFFSET(10'd0), .SLABEL(3'b010)) dut0 (
        .clk(clk), .rst(rst), .txsof(txsof), .din_vld(din_vld0), .datain(datain0),
        .din_rdy(rdy0), .rden(rden), .addrrd(addrrd), .dout(dout0), .dout_vld(vld0),
        .rei_in(rei), .rdi_in(rdi), .fifo_lvl(lvl0), .undflw(uf0));

    igrtu12 #(.ADDR(SLOT), .WIDTH(8), .OFFSET(10'd105), .SLABEL(3'b010)) dut1 (
        .clk(clk), .rst(rst), .txsof(txsof), .din_vld(din_vld1), .datain(datain1),
        .din_rdy(rdy1), .rden(rden), .addrrd(addrrd), .dout(dout1), .dout_vld(vld1),
        .rei_in(rei), .rdi_in(rdi), .fifo_lvl(lvl1), .undflw(uf1));

    typedef struct packed {
        int         row;
        logic [7:0] b;
        logic       uf;
    } exp_t;

    exp_t       sb0[$], sb1[$];
    exp_t       e0, e1;
    logic [7:0] mf0[$];
    int         m_row[2];
    logic [1:0] m_bip[2];
    logic [7:0] cap0[144], cap1[144];
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Row kind from the pointer value: 0 ptr, 1 V5, 2 J2/N2/K4, 3 stuff, 4 data.
    function automatic int rtype(input int off, input int row);
        int v5row, p, rel;
        if (row % 36 == 0) return 0;
        if (off < 35)       v5row = off + 37;
        else if (off < 70)  v5row = off + 38;
        else if (off < 105) v5row = off + 39;
        else                v5row = off - 104;
        if (row == v5row) return 1;
        p   = off % 35;
        rel = row % 36 - 1;
        if (rel == p) return 2;
        if (rel == (p + 1) % 35) return 3;
        return 4;
    endfunction

    function automatic logic [1:0] par2(input logic [7:0] b);
        return {b[7] ^ b[5] ^ b[3] ^ b[1], b[6] ^ b[4] ^ b[2] ^ b[0]};
    endfunction

    task automatic model_read(input int inst, input int off, input bit sof, input bit svc);
        int         r, t;
        logic [7:0] b;
        logic [9:0] o10;
        bit         u;
        exp_t       e;
        r = sof ? 0 : m_row[inst];
        if (svc) begin
            u   = 1'b0;
            o10 = off[9:0];
            t   = rtype(off, r);
            case (t)
                0: b = (r == 0) ? {6'b011010, o10[9:8]} : (r == 36) ? o10[7:0] : 8'h00;
                1: b = {m_bip[inst], rei, 1'b0, 3'b010, rdi};
                2: b = 8'h00;
                3: b = 8'hFF;
                default: begin
                    if (inst == 0 && mf0.size() > 0) b = mf0.pop_front();
                    else begin
                        b = 8'hFF;
                        u = 1'b1;
                    end
                end
            endcase
            if (t == 1)      m_bip[inst] = par2(b);
            else if (t != 0) m_bip[inst] = m_bip[inst] ^ par2(b);
            e.row = r;
            e.b   = b;
            e.uf  = u;
            if (inst == 0) sb0.push_back(e);
            else           sb1.push_back(e);
            r = (r == 143) ? 0 : r + 1;
        end
        m_row[inst] = r;
    endtask

    // Called at posedge+1; drives one cycle of stimulus and predicts it.
    task automatic step(input bit rd, input logic [4:0] ad, input bit sof,
                        input bit wv, input logic [7:0] wd);
        int pre;
        check("din_rdy0", rdy0, (mf0.size() != 16));
        check("fifo_lvl0", lvl0, mf0.size());
        check("fifo_lvl1", lvl1, 0);
        rden    = rd;
        addrrd  = ad;
        txsof   = sof;
        din_vld0 = wv;
        datain0 = wd;
        pre = mf0.size();
        model_read(0, 0, sof, rd && (ad == SLOT));
        model_read(1, 105, sof, rd && (ad == SLOT));
        if (wv && pre < 16) mf0.push_back(wd);
        @(posedge clk);
        #1;
        rden     = 1'b0;
        txsof    = 1'b0;
        din_vld0 = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        m_row[0] = 0;
        m_row[1] = 0;
        m_bip[0] = 2'd0;
        m_bip[1] = 2'd0;
        mf0.delete();
        check("rst_lvl0", lvl0, 0);
        check("rst_rdy0", rdy0, 1);
        check("rst_dout0", dout0, 0);
        check("rst_vld0", vld0, 0);
        check("rst_uf0", uf0, 0);
        check("rst_vld1", vld1, 0);
        check("rst_lvl1", lvl1, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (vld0) begin
                if (sb0.size() == 0) check("dut0_unexpected_vld", 1, 0);
                else begin
                    e0 = sb0.pop_front();
                    check($sformatf("dut0_row%0d_byte", e0.row), dout0, e0.b);
                    check($sformatf("dut0_row%0d_undflw", e0.row), uf0, e0.uf);
                    cap0[e0.row] = dout0;
                end
            end else if (uf0) check("dut0_undflw_without_vld", 1, 0);
            if (vld1) begin
                if (sb1.size() == 0) check("dut1_unexpected_vld", 1, 0);
                else begin
                    e1 = sb1.pop_front();
                    check($sformatf("dut1_row%0d_byte", e1.row), dout1, e1.b);
                    check($sformatf("dut1_row%0d_undflw", e1.row), uf1, e1.uf);
                    cap1[e1.row] = dout1;
                end
            end else if (uf1) check("dut1_undflw_without_vld", 1, 0);
        end
    end

    initial begin
        int guard;
        for (int i = 0; i < 144; i++) begin
            cap0[i] = 8'h5A;
            cap1[i] = 8'h5A;
        end
        do_reset();

        // Empty FIFO, one full multiframe on both offsets.
        for (int i = 0; i < 144; i++) step(1'b1, SLOT, i == 0, 1'b0, 8'h00);
        @(negedge clk);
        #1;
        check("off0_v1", cap0[0], 8'h68);
        check("off0_v2", cap0[36], 8'h00);
        check("off0_v5", cap0[37], 8'h04);
        check("off0_r38", cap0[38], 8'hFF);
        check("off0_poh1", cap0[1], 8'h00);
        check("off0_fill5", cap0[5], 8'hFF);
        check("off105_v1", cap1[0], 8'h68);
        check("off105_v2", cap1[36], 8'h69);
        check("off105_v5", cap1[1], 8'h04);
        check("off105_j2", cap1[37], 8'h00);
        check("off105_r2", cap1[2], 8'hFF);

        // Two multiframes fed with 132 bytes of 8'h01, rei=1 rdi=0.
        rei = 1'b1;
        rdi = 1'b0;
        for (int i = 0; i < 144; i++) step(1'b1, SLOT, i == 0, i < 132, 8'h01);
        @(negedge clk);
        #1;
        check("first_fed_v5", cap0[37], 8'h24);
        for (int i = 0; i < 144; i++) step(1'b1, SLOT, i == 0, i < 132, 8'h01);
        @(negedge clk);
        #1;
        check("second_fed_v5", cap0[37], 8'hE4);
        rei = 1'b0;
        @(posedge clk);
        #1;

        // Fill to 16, one refused write, then drain one byte via data row 3.
        for (int i = 0; i < 16; i++) step(1'b0, SLOT, 1'b0, 1'b1, 8'hA0 + 8'(i));
        step(1'b0, SLOT, 1'b0, 1'b1, 8'hEE);
        check("full_rdy", rdy0, 0);
        check("full_lvl", lvl0, 16);
        for (int i = 0; i < 4; i++) step(1'b1, SLOT, 1'b0, 1'b0, 8'h00);
        check("after_pop_rdy", rdy0, 1);
        check("after_pop_lvl", lvl0, 15);

        // Wrong slot address: nothing emitted, row kept.
        step(1'b1, SLOT + 5'd1, 1'b0, 1'b0, 8'h00);
        check("addr_miss_vld", vld0, 0);
        check("addr_miss_row", m_row[0], 4);
        guard = 0;
        while (m_row[0] != 90 && guard < 200) begin
            step(1'b1, SLOT, 1'b0, 1'b0, 8'h00);
            guard++;
        end
        check("reach_row90", m_row[0], 90);
        step(1'b1, SLOT, 1'b1, 1'b0, 8'h00);
        check("txsof_row90_v1", dout0, 8'h68);
        check("txsof_row90_vld", vld0, 1);

        // Reset mid-multiframe with 7 bytes queued.
        guard = 0;
        while (m_row[0] != 50 && guard < 200) begin
            step(1'b1, SLOT, 1'b0, 1'b0, 8'h00);
            guard++;
        end
        for (int i = 0; i < 7; i++) step(1'b0, SLOT, 1'b0, 1'b1, 8'hC0 + 8'(i));
        check("pre_rst_lvl", lvl0, 7);
        do_reset();
        step(1'b1, SLOT, 1'b0, 1'b0, 8'h00);
        check("post_rst_v1", dout0, 8'h68);
        check("post_rst_v1_off105", dout1, 8'h68);
        step(1'b1, SLOT, 1'b0, 1'b0, 8'h00);

        @(negedge clk);
        #1;
        check("sb0_drained", sb0.size(), 0);
        check("sb1_drained", sb1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/igrtu12.md
IGRTU12 -- requirements
Module: igrtu12

Interface
REQ-001 Parameter: ADDR, 5'b0, TU12 slot address this instance answers to on the read bus.
REQ-002 Parameter: WIDTH, 8, byte width of data paths.
REQ-003 Parameter: OFFSET, 10'd0, fixed TU12 pointer value (0..139) transmitted in V1/V2.
REQ-004 Parameter: SLABEL, 3'b010, V5 signal label (asynchronous mapping).
REQ-005 Ports: clk  in  1  single clock; all flops on rising edge.
REQ-006 Ports: rst  in  1  reset, asynchronous and active-high.
REQ-007 Ports: txsof  in  1  multiframe start pulse; next read slot is byte 0 (V1).
REQ-008 Ports: din_vld  in  1, datain  in  WIDTH  E1 byte offer; din_rdy  out  1  accept (write when din_vld & din_rdy).
REQ-009 Ports: rden  in  1, addrrd  in  5  slot read request; serviced only when addrrd == ADDR.
REQ-010 Ports: dout  out  WIDTH, dout_vld  out  1  transmitted TU12 byte.
REQ-011 Ports: rei_in  in  1, rdi_in  in  1  far-end indications inserted into V5.
REQ-012 Ports: fifo_lvl  out  5  FIFO occupancy; undflw  out  1  one-cycle pulse on fill-byte insertion.

Function
REQ-013 Byte counter row 0..143 SHALL advance by 1 per serviced read and wrap 143 -> 0.
REQ-014 txsof SHALL force row to 0, taking precedence over a same-cycle serviced read; that read emits byte 0.
REQ-015 Serviced read at cycle N SHALL drive dout/dout_vld at cycle N+1; dout_vld low otherwise, dout holds last value.
REQ-016 Pointer rows: row 0 -> V1 = {4'b0110, 2'b10, OFFSET[9:8]}; row 36 -> V2 = OFFSET[7:0]; rows 72, 108 -> V3 = V4 = 8'h00.
REQ-017 V5 row: OFFSET 0..34 -> OFFSET+37; 35..69 -> OFFSET+38; 70..104 -> OFFSET+39; 105..139 -> OFFSET-104.
REQ-018 POH offset p = V5 position relative to its 35-byte frame (OFFSET mod 35); J2, N2, K4 SHALL occupy relative position p in the other three frames and be sent as 8'h00.
REQ-019 Fixed stuff R bytes: the byte immediately following each of the four POH bytes (frame-relative wrap 34 -> 0), sent as 8'hFF; they do not read the FIFO.
REQ-020 All other non-pointer rows are data rows: pop FIFO head if non-empty; if empty send 8'hFF and pulse undflw in the dout_vld cycle.
REQ-021 V5 = {bip[1:0], rei_in, 1'b0 (RFI), SLABEL, rdi_in}, rei_in/rdi_in sampled on the V5 read cycle.
REQ-022 BIP-2: bip[1] = even parity of bits 7,5,3,1; bip[0] = even parity of bits 6,4,2,0, over every byte sent since the previous V5 including that V5, excluding V1-V4.
REQ-023 On the V5 byte the accumulator SHALL restart with the parity of the V5 byte just sent.
REQ-024 txsof SHALL NOT clear the BIP accumulator.
REQ-025 FIFO: 16 x WIDTH, fifo_lvl 0..16, din_rdy = (fifo_lvl != 16); write and pop in the same cycle leave fifo_lvl unchanged.
REQ-026 Write to an empty FIFO coinciding with a data-row read SHALL still send fill (no bypass); written byte is stored.

Reset
REQ-027 rst SHALL asynchronously clear row, BIP accumulator, FIFO pointers, fifo_lvl, dout, dout_vld, undflw; din_rdy = 1 after reset.
REQ-028 rst asserted mid-multiframe SHALL discard FIFO contents; first read after release emits byte 0 (V1).

Verification
REQ-029 OFFSET=0, txsof, 144 reads, FIFO empty -> row0=8'h68, row36=8'h00, row37 V5, row38 8'hFF stuff, data rows 8'hFF with undflw.
REQ-030 OFFSET=105 -> V1=8'h68, V2=8'h69, V5 at row 1, J2 at row 37, R at row 2.
REQ-031 Feed 132 bytes 8'h01 per multiframe, OFFSET=0, rei_in=1, rdi_in=0 -> second V5 = {bip, 1, 0, 010, 0}, bip matching REQ-022 model.
REQ-032 Fill FIFO to 16 -> din_rdy=0, fifo_lvl=16; one data-row read -> din_rdy=1 next cycle.
REQ-033 rden with addrrd != ADDR -> no dout_vld, row unchanged; txsof with rden at row 90 -> dout=V1.
REQ-034 rst pulse at row 50 with fifo_lvl=7 -> fifo_lvl=0, next read returns V1.
